mul_div_unit: RTL and testbench
===============================

# mul_div_unit

Multi-cycle integer multiply/divide unit with its own HI/LO register pair. It is the parametrised successor to the single-cycle ALU. HI/LO move operations are no longer passed through the ALU result; they live here, alongside iterative signed and unsigned MULT/DIV. It sits beside the ALU in the execute stage, and the pipeline stalls on `busy`.

## Interface
- `WIDTH`, default 32: operand width. HI and LO are each WIDTH bits. Must be ≥ 4.
- `CNT_W`, default $clog2(WIDTH)+1: width of the iteration counter.
- `clk`  in  1  Rising-edge clock, the only clock in the block.
- `rst`  in  1  Reset, synchronous and active-high.
- `start`  in  1  Request; sampled on the clock edge.
- `op`  in  3  Operation: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6–7 reserved (treated as no-op).
- `a`  in  WIDTH  Operand rs: multiplicand, dividend, or MTHI/MTLO source.
- `b`  in  WIDTH  Operand rt: multiplier or divisor.
- `cancel`  in  1  Pipeline flush; aborts the operation in flight.
- `busy`  out  1  High while MULT/DIV is in progress. `ready` = !busy.
- `done`  out  1  One-cycle pulse after MULT/DIV writes HI/LO.
- `hi`  out  WIDTH  HI register, read by MFHI.
- `lo`  out  WIDTH  LO register, read by MFLO.

## Operation
- Reset: `hi` = 0, `lo` = 0, `busy` = 0, `done` = 0, FSM in IDLE, counter = 0.
- FSM states:
  - IDLE to CALC: `start` & op ∈ {0..3} & !`cancel`. Latches operand magnitudes and the result-sign flags, loads counter = WIDTH, sets `busy`.
  - CALC: one iteration per cycle, counter decrements. Leaves CALC for FIX when counter reaches 1 on that edge.
  - FIX: applies signs, writes `hi`/`lo`, clears `busy`, sets `done`, returns to IDLE.
- MTHI / MTLO in IDLE:
  - `hi` ← `a` (or `lo` ← `a`) on the sampling edge.
  - No `busy`, no `done`.
  - Ignored while busy.
- Reserved op codes: no effect.
- `start` while `busy`: ignored. The requester holds `start` until it sees `busy` = 0.
- MULT/MULTU:
  - Radix-2 shift-add on magnitudes, 2·WIDTH-bit product.
  - Signed: operands are converted to magnitude. The product is negated in FIX when sign(a) ≠ sign(b).
  - `hi` = product[2W-1:W], `lo` = product[W-1:0].
- DIV/DIVU:
  - Restoring division on magnitudes, one quotient bit per cycle.
  - `lo` = quotient, truncated toward zero.
  - `hi` = remainder, with the sign of the dividend (signed op).
- Divide by zero (b = 0), both signed and unsigned: `lo` = all ones, `hi` = `a`. Takes the full latency.
- Signed overflow (a = most-negative, b = −1): `lo` = most-negative, `hi` = 0.
- `cancel`:
  - In CALC or FIX: next edge goes to IDLE, `busy` = 0, `hi`/`lo` unchanged, no `done`.
  - In IDLE: blocks any `start` in the same cycle, including MTHI/MTLO.
  - Cancel wins over start in every case.
- `rst` mid-operation: full reset, as above. The result is lost.

## Timing
- Define edge E0 as the edge that samples `start`.
- `busy` is high from after E0 to after E(WIDTH+1): WIDTH+1 cycles in total, 33 at WIDTH = 32.
- `hi`/`lo` update at E(WIDTH+1). `done` is high for exactly the one cycle following that edge, while the new values are already visible.
- Back-to-back: a `start` sampled in the `done` cycle is accepted. Sustained throughput is one op per WIDTH+2 cycles.
- MTHI/MTLO: the new value is visible on `hi`/`lo` the cycle after E0.
- MFHI/MFLO hazard (reading `hi`/`lo` while `busy`) is the pipeline's responsibility. `hi`/`lo` hold their old values until FIX.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Test plan
All values at WIDTH = 32.
- Reset, then MULT a=0xFFFFFFFE b=0x00000003 → `busy` for 33 cycles, then `done` pulse; `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFA. MULTU with the same operands → `hi`=0x00000002, `lo`=0xFFFFFFFA.
- DIV a=0xFFFFFFF9 (−7) b=2 → `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=100 b=7 → `lo`=0x0000000E, `hi`=0x00000002.
- DIVU a=5 b=0 → `lo`=0xFFFFFFFF, `hi`=0x00000005. DIV a=0x80000000 b=0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- MTHI a=0x12345678, then MTLO a=0x9ABCDEF0 on consecutive cycles → `hi`/`lo` update one cycle each, `busy` and `done` stay 0. MTHI while busy → ignored.
- Preload `hi`/`lo`, start DIVU, assert `cancel` in cycle 10 → `busy` = 0 next cycle, `hi`/`lo` still the preloaded values, no `done`. Also: `start` + `cancel` in the same cycle → ignored. `rst` mid-MULT → all outputs 0.
- Hold `start` with MULTU throughout an op → second op accepted in the `done` cycle. Random signed and unsigned operands checked against a reference model, including 0, 1, −1, and most-negative.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle integer multiply/divide unit that owns the HI/LO
// register pair.
//
// MULT/MULTU use radix-2 shift-add on operand magnitudes.
// DIV/DIVU use restoring division on operand magnitudes.
// Signs are applied in a final FIX cycle.
// MTHI/MTLO write HI/LO directly in one cycle when the unit is idle.
//
// Ports:
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  request, sampled on the clock edge
//   op     0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op
//   a      multiplicand / dividend / MTHI-MTLO source
//   b      multiplier / divisor
//   cancel pipeline flush; aborts an operation in flight, blocks a start
//   busy   high while MULT/DIV is in progress
//   done   one-cycle pulse after MULT/DIV has written HI/LO
//   hi     HI register
//   lo     LO register
//
// State table:
//   IDLE | waiting for a request; MTHI/MTLO handled here
//   CALC | one multiply/divide iteration per cycle
//   FIX  | apply result signs, write HI/LO, pulse done
module mul_div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [CNT_W-1:0]   cnt;
  // Multiply: {partial product high, multiplier shifting out at bit 0}.
  // Divide:   {partial remainder, dividend shifting out at the top / quotient in}.
  logic [2*WIDTH-1:0] work;
  logic [WIDTH-1:0]   mag_b;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   hi_q, lo_q;
  logic               done_q;

  logic               accept;
  logic               signed_op;
  logic               a_neg, b_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     rem_shift;
  logic               rem_ge;
  logic [WIDTH-1:0]   rem_nxt;

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Only MULT/MULTU/DIV/DIVU (op < 4) enter CALC.
  assign accept    = (state == IDLE) && start && !cancel && (op[2] == 1'b0);
  assign signed_op = ~op[0];
  assign a_neg     = signed_op & a[WIDTH-1];
  assign b_neg     = signed_op & b[WIDTH-1];
  // The most-negative value maps to itself, which is its correct unsigned magnitude.
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;

  assign mul_sum   = {1'b0, work[2*WIDTH-1:WIDTH]} + {1'b0, (work[0] ? mag_b : {WIDTH{1'b0}})};

  assign rem_shift = {work[2*WIDTH-1:WIDTH], work[WIDTH-1]};
  assign rem_ge    = rem_shift >= {1'b0, mag_b};
  // Subtraction is taken modulo 2^WIDTH.
  // When rem_ge is set the true difference is below mag_b, so it fits in WIDTH bits.
  assign rem_nxt   = rem_ge ? (rem_shift[WIDTH-1:0] - mag_b) : rem_shift[WIDTH-1:0];

  assign prod_fix  = neg_main ? -work : work;
  assign quo_fix   = neg_main ? -work[WIDTH-1:0] : work[WIDTH-1:0];
  assign rem_fix   = neg_rem ? -work[2*WIDTH-1:WIDTH] : work[2*WIDTH-1:WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = CALC;
      CALC: begin
        if (cancel)                    state_nxt = IDLE;
        else if (cnt == CNT_W'(1))     state_nxt = FIX;
      end
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      work     <= '0;
      mag_b    <= '0;
      is_div   <= 1'b0;
      neg_main <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !cancel) begin
            case (op)
              OP_MTHI: hi_q <= a;
              OP_MTLO: lo_q <= a;
              OP_MULT, OP_MULTU: begin
                cnt      <= CNT_W'(WIDTH);
                work     <= {{WIDTH{1'b0}}, b_mag};
                mag_b    <= a_mag;
                is_div   <= 1'b0;
                neg_main <= a_neg ^ b_neg;
                neg_rem  <= 1'b0;
                div_zero <= 1'b0;
              end
              OP_DIV, OP_DIVU: begin
                cnt      <= CNT_W'(WIDTH);
                work     <= {{WIDTH{1'b0}}, a_mag};
                mag_b    <= b_mag;
                is_div   <= 1'b1;
                neg_main <= a_neg ^ b_neg;
                neg_rem  <= a_neg;
                div_zero <= (b == '0);
              end
              default: ;
            endcase
          end
        end
        CALC: begin
          if (!cancel) begin
            cnt <= cnt - CNT_W'(1);
            if (is_div) work <= {rem_nxt, work[WIDTH-2:0], rem_ge};
            else        work <= {mul_sum, work[WIDTH-1:1]};
          end
        end
        FIX: begin
          if (!cancel) begin
            if (is_div) begin
              // Divide by zero: the remainder path already yields a (its magnitude
              // re-signed by the dividend); only LO needs forcing to all ones.
              lo_q <= div_zero ? {WIDTH{1'b1}} : quo_fix;
              hi_q <= rem_fix;
            end else begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end
            done_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        cancel;
  logic        busy, done;
  logic [31:0] hi, lo;

  int tests = 0;
  int fails = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  // Independent reference model built on native 64-bit arithmetic.
  task automatic ref_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] rh, output logic [31:0] rl);
    longint          sp;
    longint unsigned up;
    int              sx, sy;
    sx = $signed(x);
    sy = $signed(y);
    rh = 32'h0;
    rl = 32'h0;
    case (o)
      3'd0: begin
        sp = longint'(sx) * longint'(sy);
        rh = sp[63:32];
        rl = sp[31:0];
      end
      3'd1: begin
        up = {32'h0, x} * {32'h0, y};
        rh = up[63:32];
        rl = up[31:0];
      end
      3'd2: begin
        if (y == 32'h0) begin
          rl = 32'hFFFF_FFFF;
          rh = x;
        end else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
          rl = 32'h8000_0000;
          rh = 32'h0;
        end else begin
          rl = sx / sy;
          rh = sx % sy;
        end
      end
      3'd3: begin
        if (y == 32'h0) begin
          rl = 32'hFFFF_FFFF;
          rh = x;
        end else begin
          rl = x / y;
          rh = x % y;
        end
      end
      default: ;
    endcase
  endtask

  // Issues one op and waits for busy to drop. Returns busy length and done at that point.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        output int bcyc, output logic dn);
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y;
    @(negedge clk);
    start = 1'b0;
    bcyc = 0;
    while (busy && bcyc < 100) begin
      bcyc++;
      @(negedge clk);
    end
    dn = done;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; op = 3'd0; a = '0; b = '0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      fails++;
      $display("FAIL reset: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
  endtask

  task automatic test_mult();
    int bc; logic dn;
    run_op(3'd0, 32'hFFFF_FFFE, 32'h0000_0003, bc, dn);
    tests++;
    if (bc !== 33) begin fails++; $display("FAIL mult_busy_len: got %0d expected 33", bc); end
    tests++;
    if (dn !== 1'b1) begin fails++; $display("FAIL mult_done: got %b expected 1", dn); end
    tests++;
    if ({hi, lo} !== 64'hFFFF_FFFF_FFFF_FFFA) begin
      fails++; $display("FAIL mult_result: hi=%h lo=%h expected ffffffff fffffffa", hi, lo);
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b expected 0", done); end
    run_op(3'd1, 32'hFFFF_FFFE, 32'h0000_0003, bc, dn);
    tests++;
    if ({dn, hi, lo} !== {1'b1, 64'h0000_0002_FFFF_FFFA}) begin
      fails++; $display("FAIL multu_result: done=%b hi=%h lo=%h expected 1 00000002 fffffffa", dn, hi, lo);
    end
  endtask

  task automatic test_div();
    int bc; logic dn;
    run_op(3'd2, 32'hFFFF_FFF9, 32'h2, bc, dn);
    tests++;
    if ({bc, dn, hi, lo} !== {32'd33, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD}) begin
      fails++; $display("FAIL div_neg: busy=%0d done=%b hi=%h lo=%h expected 33 1 ffffffff fffffffd", bc, dn, hi, lo);
    end
    run_op(3'd3, 32'd100, 32'd7, bc, dn);
    tests++;
    if ({hi, lo} !== {32'd2, 32'd14}) begin
      fails++; $display("FAIL divu: hi=%h lo=%h expected 00000002 0000000e", hi, lo);
    end
    run_op(3'd3, 32'd5, 32'd0, bc, dn);
    tests++;
    if ({bc, hi, lo} !== {32'd33, 32'd5, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL divu_by_zero: busy=%0d hi=%h lo=%h expected 33 00000005 ffffffff", bc, hi, lo);
    end
    run_op(3'd2, 32'hFFFF_FFF9, 32'd0, bc, dn);
    tests++;
    if ({hi, lo} !== {32'hFFFF_FFF9, 32'hFFFF_FFFF}) begin
      fails++; $display("FAIL div_by_zero_signed: hi=%h lo=%h expected fffffff9 ffffffff", hi, lo);
    end
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, bc, dn);
    tests++;
    if ({hi, lo} !== {32'h0, 32'h8000_0000}) begin
      fails++; $display("FAIL div_overflow: hi=%h lo=%h expected 00000000 80000000", hi, lo);
    end
  endtask

  task automatic test_mt();
    int bc; logic dn;
    logic [31:0] old_lo;
    old_lo = lo;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1234_5678;
    @(negedge clk);
    tests++;
    if ({hi, lo, busy, done} !== {32'h1234_5678, old_lo, 2'b00}) begin
      fails++; $display("FAIL mthi: hi=%h lo=%h busy=%b done=%b expected 12345678 %h 0 0", hi, lo, busy, done, old_lo);
    end
    op = 3'd5; a = 32'h9ABC_DEF0;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({hi, lo, busy, done} !== {32'h1234_5678, 32'h9ABC_DEF0, 2'b00}) begin
      fails++; $display("FAIL mtlo: hi=%h lo=%h busy=%b done=%b expected 12345678 9abcdef0 0 0", hi, lo, busy, done);
    end
    // Reserved op: no effect.
    start = 1'b1; op = 3'd6; a = 32'hDEAD_BEEF;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    tests++;
    if ({hi, lo, busy} !== {32'h1234_5678, 32'h9ABC_DEF0, 1'b0}) begin
      fails++; $display("FAIL reserved_op: hi=%h lo=%h busy=%b expected 12345678 9abcdef0 0", hi, lo, busy);
    end
    // MTHI while busy is ignored; the MULTU result lands later.
    start = 1'b1; op = 3'd1; a = 32'd6; b = 32'd7;
    @(negedge clk);
    op = 3'd4; a = 32'hAAAA_5555;
    @(negedge clk);
    start = 1'b0;
    tests++;
    if ({hi, busy} !== {32'h1234_5678, 1'b1}) begin
      fails++; $display("FAIL mthi_while_busy: hi=%h busy=%b expected 12345678 1", hi, busy);
    end
    bc = 0;
    while (busy && bc < 100) begin bc++; @(negedge clk); end
    dn = done;
    tests++;
    if ({dn, hi, lo} !== {1'b1, 32'h0, 32'd42}) begin
      fails++; $display("FAIL multu_after_mthi: done=%b hi=%h lo=%h expected 1 00000000 0000002a", dn, hi, lo);
    end
  endtask

  task automatic test_cancel();
    int dcount;
    @(negedge clk);
    start = 1'b1; op = 3'd4; a = 32'h1111_2222;
    @(negedge clk);
    op = 3'd5; a = 32'h3333_4444;
    @(negedge clk);
    op = 3'd3; a = 32'd1000; b = 32'd3;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    cancel = 1'b1;
    @(negedge clk);
    cancel = 1'b0;
    tests++;
    if ({busy, done, hi, lo} !== {2'b00, 32'h1111_2222, 32'h3333_4444}) begin
      fails++; $display("FAIL cancel_calc: busy=%b done=%b hi=%h lo=%h expected 0 0 11112222 33334444", busy, done, hi, lo);
    end
    dcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) dcount++;
    end
    tests++;
    if (dcount !== 0) begin fails++; $display("FAIL cancel_no_done: got %0d done cycles expected 0", dcount); end
    // start + cancel in the same cycle, for a multiply and for MTHI.
    start = 1'b1; cancel = 1'b1; op = 3'd1; a = 32'd9; b = 32'd9;
    @(negedge clk);
    op = 3'd4; a = 32'h5555_6666;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0;
    tests++;
    if ({busy, hi, lo} !== {1'b0, 32'h1111_2222, 32'h3333_4444}) begin
      fails++; $display("FAIL start_with_cancel: busy=%b hi=%h lo=%h expected 0 11112222 33334444", busy, hi, lo);
    end
    // rst mid-MULT.
    start = 1'b1; op = 3'd0; a = 32'd12; b = 32'd12;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    tests++;
    if ({busy, done, hi, lo} !== 66'h0) begin
      fails++; $display("FAIL rst_mid_mult: busy=%b done=%b hi=%h lo=%h expected all 0", busy, done, hi, lo);
    end
    repeat (40) @(negedge clk);
    tests++;
    if ({done, hi, lo} !== 65'h0) begin
      fails++; $display("FAIL rst_result_lost: done=%b hi=%h lo=%h expected 0", done, hi, lo);
    end
  endtask

  task automatic test_back_to_back();
    int n, m;
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd5;
    n = 0;
    while (!done && n < 200) begin @(negedge clk); n++; end
    tests++;
    if ({n, lo} !== {32'd34, 32'd15}) begin
      fails++; $display("FAIL b2b_first: cycles=%0d lo=%h expected 34 0000000f", n, lo);
    end
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b10) begin
      fails++; $display("FAIL b2b_accept: busy=%b done=%b expected 1 0", busy, done);
    end
    a = 32'd7;
    m = 1;
    while (!done && m < 200) begin @(negedge clk); m++; end
    start = 1'b0;
    tests++;
    if ({m, hi, lo} !== {32'd34, 32'h0, 32'd15}) begin
      fails++; $display("FAIL b2b_throughput: cycles=%0d hi=%h lo=%h expected 34 00000000 0000000f", m, hi, lo);
    end
    @(negedge clk);
    @(negedge clk);
    tests++;
    if ({busy, done} !== 2'b00) begin
      fails++; $display("FAIL b2b_settle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_model();
    logic [31:0] va [0:9];
    logic [31:0] vb [0:9];
    logic [31:0] eh, el;
    int bc; logic dn;
    va[0] = 32'h0;         vb[0] = 32'h1;
    va[1] = 32'h1;         vb[1] = 32'hFFFF_FFFF;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;
    va[3] = 32'h8000_0000; vb[3] = 32'h1;
    va[4] = 32'h8000_0000; vb[4] = 32'h8000_0000;
    va[5] = 32'h7FFF_FFFF; vb[5] = 32'h8000_0000;
    va[6] = 32'hFFFF_FFFF; vb[6] = 32'h0;
    va[7] = 32'd12345;     vb[7] = 32'hFFFF_FF85;
    va[8] = $urandom;      vb[8] = $urandom;
    va[9] = $urandom;      vb[9] = $urandom_range(1, 1000);
    for (int i = 0; i < 10; i++) begin
      for (int o = 0; o < 4; o++) begin
        ref_op(3'(o), va[i], vb[i], eh, el);
        run_op(3'(o), va[i], vb[i], bc, dn);
        tests++;
        if ({dn, hi, lo} !== {1'b1, eh, el}) begin
          fails++;
          $display("FAIL model op=%0d a=%h b=%h: done=%b hi=%h lo=%h expected 1 %h %h",
                   o, va[i], vb[i], dn, hi, lo, eh, el);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mt();
    test_cancel();
    test_back_to_back();
    test_model();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

endmodule
